// File: rtl/serial_add_ctrl_pkg.sv
// Shared types and constants for the bit-serial adder controller.
// Imported by the controller and its full-adder cell.
package serial_add_ctrl_pkg;

  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/serial_add_ctrl_fa.sv
// Single-bit full adder cell, time-shared by the serial controller.
// Purely combinational.
module fa
  import serial_add_ctrl_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full adder, WIDTH cycles, LSB first.
// Result registers hold until the next completion or reset.
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  state_t state;
  state_t state_nx;

  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic [WIDTH-1:0] sh_s;
  logic [WIDTH-1:0] sh_s_nx;
  logic [CNT_W-1:0] cnt;
  logic             carry;
  logic             fa_s;
  logic             fa_c;
  logic             last;

  fa u_fa (
    .a    (sh_a[0]),
    .b    (sh_b[0]),
    .cin  (carry),
    .s    (fa_s),
    .cout (fa_c)
  );

  assign last    = (cnt == CNT_W'(WIDTH - 1));
  assign sh_s_nx = {fa_s, sh_s[WIDTH-1:1]};

  always_comb begin
    state_nx = IDLE;
    case (state)
      IDLE:    state_nx = start ? RUN : IDLE;
      RUN:     state_nx = last ? DONE : RUN;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      sh_a  <= '0;
      sh_b  <= '0;
      sh_s  <= '0;
      cnt   <= '0;
      carry <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && start) begin
        sh_a  <= a;
        sh_b  <= b;
        carry <= cin;
        cnt   <= '0;
      end else if (state == RUN) begin
        sh_a  <= sh_a >> 1;
        sh_b  <= sh_b >> 1;
        sh_s  <= sh_s_nx;
        carry <= fa_c;
        cnt   <= cnt + 1'b1;
        if (last) begin
          sum  <= sh_s_nx;
          cout <= fa_c;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl at WIDTH=8.
// Expected values are hand-computed constants.
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  int total = 0;
  int bad = 0;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input string tag,
                        input logic [W-1:0] va,
                        input logic [W-1:0] vb,
                        input logic vc,
                        input logic [W-1:0] es,
                        input logic ec);
    int k;
    a = va;
    b = vb;
    cin = vc;
    start = 1'b1;
    step();
    start = 1'b0;
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    k = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (done) begin
        k = i;
        break;
      end
    end
    chk({tag, "_lat"}, 32'(k), 32'(W));
    chk({tag, "_sum"}, 32'(sum), 32'(es));
    chk({tag, "_cout"}, 32'(cout), 32'(ec));
    step();
    chk({tag, "_done_off"}, 32'(done), 32'd0);
    chk({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int n_done;
    int gap;
    int low;
    logic [W-1:0] cap;

    rst_n = 1'b0;
    step();
    step();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    rst_n = 1'b1;
    step();

    // 1-2: basic and carry-ripple sums
    run_op("t1", 8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0);
    run_op("t2a", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    run_op("t2b", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);

    // 3: start held high
    a = 8'h10;
    b = 8'h20;
    cin = 1'b0;
    start = 1'b1;
    n_done = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (done) break;
    end
    chk("t3_first", 32'(done), 32'd1);
    for (int p = 0; p < 2; p++) begin
      gap = 0;
      low = 0;
      for (int i = 1; i <= 30; i++) begin
        step();
        if (!busy) low++;
        if (done) begin
          gap = i;
          break;
        end
      end
      chk("t3_gap", 32'(gap), 32'd10);
      chk("t3_low", 32'(low), 32'd1);
      chk("t3_sum", 32'(sum), 32'h30);
      chk("t3_cout", 32'(cout), 32'd0);
    end
    start = 1'b0;
    step();
    step();
    chk("t3_idle", 32'(busy), 32'd0);

    // 4: start pulses and operand changes during RUN
    a = 8'h01;
    b = 8'h02;
    start = 1'b1;
    step();
    start = 1'b0;
    n_done = 0;
    cap = '0;
    for (int i = 1; i <= 30; i++) begin
      step();
      if (done) begin
        n_done++;
        cap = sum;
      end
      start = (i == 3 || i == 5);
      if (i == 3) begin
        a = 8'hAA;
        b = 8'h55;
      end
    end
    start = 1'b0;
    chk("t4_ndone", 32'(n_done), 32'd1);
    chk("t4_sum", 32'(cap), 32'h03);
    chk("t4_idle", 32'(busy), 32'd0);

    // 5: reset mid-run
    a = 8'h80;
    b = 8'h80;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_done", 32'(done), 32'd0);
    chk("t5_sum", 32'(sum), 32'd0);
    chk("t5_cout", 32'(cout), 32'd0);
    n_done = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (done || busy) n_done++;
    end
    chk("t5_quiet", 32'(n_done), 32'd0);
    run_op("t5b", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1);

    // 6: result hold across idle and the next RUN
    run_op("t6a", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0);
    for (int i = 0; i < 20; i++) step();
    chk("t6_idle_hold", 32'(sum), 32'h10);
    a = 8'h00;
    b = 8'h00;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 1; i < W; i++) begin
      step();
      chk("t6_run_hold", 32'(sum), 32'h10);
      chk("t6_run_nodone", 32'(done), 32'd0);
    end
    step();
    chk("t6_done", 32'(done), 32'd1);
    chk("t6_sum", 32'(sum), 32'h00);
    chk("t6_cout", 32'(cout), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
